mac_accum: RTL and testbench
============================

# mac_accum

Sign-magnitude multiply-accumulate stage feeding the 8-bit requantiser in the convolution datapath. Accepts LEN activation/weight pairs (8-bit sign-magnitude each) over a valid/ready handshake. Forms each product, sums them in two's complement, and presents one Width-bit sign-magnitude result whose binary point is the sum of the two input binary points. The result goes directly to the align/requantise stage.

## Interface
Parameters:
- LEN, 9: products per output; legal range 1..255.
- Width, 20: output width; bit Width-1 is the sign, bits Width-2:0 are the magnitude.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  an input pair is offered.
- in_ready  out  1  the block can accept a pair.
- in_act  in  8  activation: [7] sign, [6:0] magnitude.
- in_wgt  in  8  weight: [7] sign, [6:0] magnitude.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the downstream stage accepts the result.
- out_data  out  Width  result: [Width-1] sign, [Width-2:0] magnitude.
- bias  in  Width  sign-magnitude bias at the product binary point. Present only with MAC_BIAS_EN.

## Operation
- Input transfer occurs when in_valid and in_ready are both high. Output transfer occurs when out_valid and out_ready are both high.
- Stage 1: prod = in_act[6:0] * in_wgt[6:0] (14-bit). prod_sign = in_act[7] ^ in_wgt[7].
  - The product is converted to signed two's complement and registered with a valid bit.
  - A zero product is always treated as positive, whatever the input signs.
- Stage 2: when the product-valid bit is set, acc <= acc + product.
  - acc is signed with width Width+8, so no internal overflow is possible for LEN ≤ 255.
- Term counter cnt, 0..LEN-1, increments on each input transfer.
- FSM states:
  - ACC: in_ready=1. An input transfer with cnt==LEN-1 moves the FSM to DRAIN.
  - DRAIN: in_ready=0. Stays one cycle while the last product is added, then moves to OUT.
  - OUT: in_ready=0, out_valid=1. On an output transfer: move to ACC, clear acc (or preload it, see Configuration), clear cnt.
- Output conversion:
  - sign = acc<0. mag = |acc|.
  - If mag > 2^(Width-1)-1, mag saturates to 2^(Width-1)-1.
  - A magnitude of zero always produces sign 0 (no negative zero).
- out_data is registered when the FSM enters OUT and held stable until the output transfer.
- When in_valid=0 in ACC, nothing changes; gaps between terms are allowed.

## Timing
- Reset values: in_ready=0 during reset, 1 from the first cycle after reset release. out_valid=0. out_data=0. acc=0. cnt=0. State = ACC.
- Latency: last input transfer at cycle t gives out_valid=1 at cycle t+2.
- Throughput: one pair per cycle in ACC. Each output costs at least 2 idle input cycles (DRAIN plus OUT).
- out_ready may be high before out_valid. A transfer in the same cycle as entering OUT is legal and returns the FSM to ACC the following cycle.
- There is no combinational path from out_ready to in_ready. in_ready is decoded from registered state only.
- Reset asserted mid-accumulation or during OUT discards the partial sum. All outputs return to their reset values asynchronously.

## Configuration
- MAC_BIAS_EN defined:
  - The bias port exists.
  - bias is sampled (sign-magnitude converted to two's complement) on the first input transfer of each group (cnt==0). It is added into acc together with that product.
- MAC_BIAS_EN undefined:
  - No bias port.
  - acc starts each group at 0.

## Structure
- Package mac_pkg holds:
  - SM8_W=8 and the state enum {ACC, DRAIN, OUT}.
  - Functions sm_to_tc (sign-magnitude to two's complement, parameterised width) and tc_to_sm_sat (two's complement to saturating sign-magnitude).
- One sub-module, sm_mult: registered 8x8 sign-magnitude multiplier with valid bit, two's-complement output, one cycle latency.
- The remaining logic (counter, FSM, accumulator, output register) lives in mac_accum.

## Test plan
- LEN=9, Width=20, bias off. Nine pairs of (+3,+4) -> out_data=20'h0006C (108). out_valid exactly 2 cycles after the 9th transfer.
- LEN=9. Pairs alternating (+127,+127) and (-127,+127), ending with (+127,+127) -> out_data=20'h03F01 (+16129). Mixed signs (+2,-5) x 9 -> 20'h8005A (-90).
- LEN=40. All pairs (+127,+127) -> magnitude saturates, out_data=20'h7FFFF. All pairs (-127,+127) -> 20'hFFFFF.
- Zero and negative-zero inputs: LEN=2, pairs (-0,+5) and (+3,-0) -> out_data=20'h00000, sign 0. Then the block returns to ACC with in_ready=1.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_data stable, in_ready=0 throughout. Raising out_ready completes the transfer and in_ready=1 the next cycle. Random in_valid gaps give the same result as a gapless stream.
- Reset mid-group: rstn low after 5 of 9 terms -> out_valid=0 and in_ready=0 immediately. After release, nine (+1,+1) pairs -> 20'h00009. With MAC_BIAS_EN and bias=20'h80005 (-5), the same stream -> 20'h00004.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared types, widths and sign-magnitude helpers for the
// mac_accum multiply-accumulate stage.
package mac_pkg;

    // Width of one sign-magnitude activation or weight.
    localparam int SM8_W  = 8;
    // Product magnitude is 7x7 = 14 bits; one more bit holds the two's-complement sign.
    localparam int PROD_W = 2 * (SM8_W - 1) + 1;
    // Working width of the conversion helpers; callers narrow the result.
    // Widths handled by the helpers must not exceed this (Width+8 <= 64).
    localparam int FN_W   = 64;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_e;

    // Sign-magnitude value of width w (sign in bit w-1) to two's complement.
    function automatic logic signed [FN_W-1:0] sm_to_tc(input logic [FN_W-1:0] sm, input int w);
        logic [FN_W-1:0] mag;
        logic            sign;
        mag  = sm & ((FN_W'(1) << (w - 1)) - FN_W'(1));
        sign = |(sm & (FN_W'(1) << (w - 1)));
        return sign ? -$signed(mag) : $signed(mag);
    endfunction

    // Two's complement to w-bit sign-magnitude, saturating the magnitude to
    // 2^(w-1)-1. A zero magnitude never carries a negative sign.
    function automatic logic [FN_W-1:0] tc_to_sm_sat(input logic signed [FN_W-1:0] tc, input int w);
        logic [FN_W-1:0] mag;
        logic [FN_W-1:0] max_mag;
        logic            neg;
        max_mag = (FN_W'(1) << (w - 1)) - FN_W'(1);
        neg     = tc[FN_W-1];
        mag     = neg ? FN_W'(-tc) : FN_W'(tc);
        if (mag > max_mag) begin
            mag = max_mag;
        end
        return (neg && (mag != '0)) ? (mag | (FN_W'(1) << (w - 1))) : mag;
    endfunction

endpackage

// File: rtl/sm_mult.sv
// sm_mult: registered 8x8 sign-magnitude multiplier. One cycle latency,
// two's-complement product with a matching valid bit.
module sm_mult
    import mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid_i,
    input  logic [SM8_W-1:0]         act_i,
    input  logic [SM8_W-1:0]         wgt_i,
    output logic                     prod_valid_o,
    output logic signed [PROD_W-1:0] prod_o
);

    logic [PROD_W-2:0]         mag;
    logic                      sign;
    logic signed [PROD_W-1:0]  prod_d;
    logic signed [PROD_W-1:0]  prod_q;
    logic                      prod_valid_q;

    // Form the product magnitude and sign; a zero product is forced positive.
    // NOTE: every variable written in an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        mag    = act_i[SM8_W-2:0] * wgt_i[SM8_W-2:0];
        sign   = (act_i[SM8_W-1] ^ wgt_i[SM8_W-1]) & (|mag);
        prod_d = PROD_W'(sm_to_tc(FN_W'({sign, mag}), PROD_W));
    end

    // Register the product; it only moves when a pair is accepted.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_valid_q <= 1'b0;
            prod_q       <= '0;
        end else begin
            prod_valid_q <= in_valid_i;
            if (in_valid_i) begin
                prod_q <= prod_d;
            end
        end
    end

    assign prod_valid_o = prod_valid_q;
    assign prod_o       = prod_q;

endmodule

// File: rtl/mac_accum.sv
// mac_accum: sign-magnitude multiply-accumulate over LEN pairs with a
// saturating Width-bit sign-magnitude result.
// Optional feature: define MAC_BIAS_EN to add a bias port that seeds each group.
module mac_accum
    import mac_pkg::*;
#(
    parameter int LEN   = 9,
    parameter int Width = 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SM8_W-1:0] in_act,
    input  logic [SM8_W-1:0] in_wgt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
`ifdef MAC_BIAS_EN
    ,
    input  logic [Width-1:0] bias
`endif
);

    // Eight guard bits cover 255 terms of up to 2^14 each without overflow.
    localparam int              ACC_W    = Width + 8;
    localparam int              CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   bias_add;
    logic [Width-1:0]          out_data_q, out_data_d;
    logic                      live_q;
    logic                      in_xfer;
    logic                      out_xfer;
    logic                      prod_valid;
    logic signed [PROD_W-1:0]  prod;

    // Handshake outputs decode registered state only; out_ready never reaches in_ready.
    assign in_ready  = live_q && (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    sm_mult u_mult (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid_i   (in_xfer),
        .act_i        (in_act),
        .wgt_i        (in_wgt),
        .prod_valid_o (prod_valid),
        .prod_o       (prod)
    );

`ifdef MAC_BIAS_EN
    logic                    first_q;
    logic signed [ACC_W-1:0] bias_q;

    // Capture the bias with the first pair of a group; it lands with that product.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_q <= 1'b0;
            bias_q  <= '0;
        end else begin
            first_q <= in_xfer && (cnt_q == '0);
            if (in_xfer && (cnt_q == '0)) begin
                bias_q <= ACC_W'(sm_to_tc(FN_W'(bias), Width));
            end
        end
    end

    assign bias_add = first_q ? bias_q : '0;
`else
    assign bias_add = '0;
`endif

    // Hold in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Next state: accept LEN pairs, one drain cycle for the last product, then hold the result.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:     if (in_xfer && (cnt_q == CNT_LAST)) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (out_xfer) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Term counter, accumulator and result register next-state.
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        if (in_xfer && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (prod_valid) begin
            acc_d = acc_q + bias_add + ACC_W'(prod);
        end
        // The last product is being added during DRAIN, so convert the sum that is about to land.
        if (state_q == DRAIN) begin
            out_data_d = Width'(tc_to_sm_sat(FN_W'(acc_d), Width));
        end
        if (out_xfer) begin
            cnt_d = '0;
            acc_d = '0;
        end
    end

    // State, counter, accumulator and result registers.
    // NOTE: the accumulator is reset as well as cleared per group, so a reset mid-group discards the partial sum.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ACC;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: self-checking bench for mac_accum. Three instances (LEN 9, 40
// and 2) share the data/out_ready inputs; only the selected one sees in_valid.
module tb_mac_accum;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  iv = 3'b000;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [7:0]  in_act = 8'h00;
    logic [7:0]  in_wgt = 8'h00;
    logic        out_ready = 1'b0;
    logic [19:0] od [3];
`ifdef MAC_BIAS_EN
    logic [19:0] bias = 20'h00000;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] act_q[$];
    logic [7:0] wgt_q[$];

    always #5 clk = ~clk;

    mac_accum #(.LEN(9), .Width(20)) u_dut9 (
        .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_act(in_act), .in_wgt(in_wgt), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0])
`ifdef MAC_BIAS_EN
        , .bias(bias)
`endif
    );

    mac_accum #(.LEN(40), .Width(20)) u_dut40 (
        .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_act(in_act), .in_wgt(in_wgt), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1])
`ifdef MAC_BIAS_EN
        , .bias(bias)
`endif
    );

    mac_accum #(.LEN(2), .Width(20)) u_dut2 (
        .clk(clk), .rstn(rstn), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_act(in_act), .in_wgt(in_wgt), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2])
`ifdef MAC_BIAS_EN
        , .bias(bias)
`endif
    );

    // Reference: signed integer dot product (plus bias), then saturating sign-magnitude.
    function automatic logic [19:0] model();
        int sum;
        int a;
        int w;
        int mag;
        sum = 0;
        foreach (act_q[i]) begin
            a = act_q[i][7] ? -int'(act_q[i][6:0]) : int'(act_q[i][6:0]);
            w = wgt_q[i][7] ? -int'(wgt_q[i][6:0]) : int'(wgt_q[i][6:0]);
            sum += a * w;
        end
`ifdef MAC_BIAS_EN
        sum += bias[19] ? -int'(bias[18:0]) : int'(bias[18:0]);
`endif
        mag = (sum < 0) ? -sum : sum;
        if (mag > 524287) mag = 524287;
        return {(sum < 0) && (mag != 0), mag[18:0]};
    endfunction

    function automatic logic [7:0] rand_sm();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic push_n(input int n, input logic [7:0] a, input logic [7:0] w);
        for (int i = 0; i < n; i++) begin
            act_q.push_back(a);
            wgt_q.push_back(w);
        end
    endtask

    // Feed the queued pairs into instance sel, then check latency, result,
    // backpressure hold and the return to ACC. Clears the queues.
    task automatic run_group(input int sel, input bit gaps, input int hold,
                             input bit early, input logic [19:0] exp, input string name);
        int waitc;
        out_ready = early;
        for (int i = 0; i < act_q.size(); i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    iv[sel] = 1'b0;
                end
            end
            @(negedge clk);
            iv[sel] = 1'b1;
            in_act  = act_q[i];
            in_wgt  = wgt_q[i];
            waitc   = 0;
            while (!ir[sel] && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            if (!ir[sel]) begin
                total++;
                bad++;
                $display("FAIL %s accept_timeout: in_ready=%b required 1 at pair %0d", name, ir[sel], i);
                iv[sel]   = 1'b0;
                out_ready = 1'b0;
                act_q.delete();
                wgt_q.delete();
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        iv[sel] = 1'b0;
        total++;
        if ({ov[sel], ir[sel]} !== 2'b00) begin
            bad++;
            $display("FAIL %s drain: out_valid,in_ready=%b required 00", name, {ov[sel], ir[sel]});
        end
        @(negedge clk);
        total++;
        if (ov[sel] !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: out_valid=%b required 1 two cycles after last transfer", name, ov[sel]);
        end
        total++;
        if (od[sel] !== exp) begin
            bad++;
            $display("FAIL %s out_data: got %05h required %05h", name, od[sel], exp);
        end
        if (!early) begin
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                total++;
                if ({ov[sel], ir[sel], od[sel]} !== {2'b10, exp}) begin
                    bad++;
                    $display("FAIL %s hold%0d: valid,ready,data=%b,%b,%05h required 1,0,%05h",
                             name, c, ov[sel], ir[sel], od[sel], exp);
                end
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if ({ov[sel], ir[sel]} !== 2'b01) begin
            bad++;
            $display("FAIL %s release: out_valid,in_ready=%b required 01", name, {ov[sel], ir[sel]});
        end
        act_q.delete();
        wgt_q.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        total++;
        if ({ir, ov} !== 6'b000000) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 000/000", ir, ov);
        end
        total++;
        if ({od[0], od[1], od[2]} !== 60'h0) begin
            bad++;
            $display("FAIL reset_data: %05h %05h %05h required 0", od[0], od[1], od[2]);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (ir !== 3'b111) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b required 111", ir);
        end
    endtask

    task automatic test_basic();
        push_n(9, 8'h03, 8'h04);
        run_group(0, 1'b0, 0, 1'b0, 20'h0006C, "basic");
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 9; i++) begin
            act_q.push_back((i % 2 == 0) ? 8'h7F : 8'hFF);
            wgt_q.push_back(8'h7F);
        end
        run_group(0, 1'b0, 0, 1'b0, 20'h03F01, "alternate");
        push_n(9, 8'h02, 8'h85);
        run_group(0, 1'b0, 10, 1'b0, 20'h8005A, "backpressure");
    endtask

    task automatic test_saturate();
        push_n(40, 8'h7F, 8'h7F);
        run_group(1, 1'b0, 0, 1'b1, 20'h7FFFF, "sat_pos");
        push_n(40, 8'hFF, 8'h7F);
        run_group(1, 1'b0, 2, 1'b0, 20'hFFFFF, "sat_neg");
    endtask

    task automatic test_zero();
        act_q.push_back(8'h80); wgt_q.push_back(8'h05);
        act_q.push_back(8'h03); wgt_q.push_back(8'h80);
        run_group(2, 1'b0, 0, 1'b0, 20'h00000, "neg_zero_in");
        act_q.push_back(8'h02); wgt_q.push_back(8'h03);
        act_q.push_back(8'h82); wgt_q.push_back(8'h03);
        run_group(2, 1'b0, 0, 1'b1, 20'h00000, "cancel_zero");
    endtask

    task automatic test_random_gaps();
        logic [7:0] sa[$];
        logic [7:0] sw[$];
        logic [19:0] exp;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 9; i++) begin
                act_q.push_back(rand_sm());
                wgt_q.push_back(rand_sm());
            end
            sa  = act_q;
            sw  = wgt_q;
            exp = model();
            run_group(0, 1'b0, 0, (r % 2) == 1, exp, "rand_gapless");
            act_q = sa;
            wgt_q = sw;
            run_group(0, 1'b1, $urandom_range(0, 3), 1'b0, exp, "rand_gaps");
        end
        for (int i = 0; i < 40; i++) begin
            act_q.push_back(rand_sm());
            wgt_q.push_back(rand_sm());
        end
        exp = model();
        run_group(1, 1'b1, 0, 1'b1, exp, "rand_len40");
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            iv[0]  = 1'b1;
            in_act = 8'h7F;
            in_wgt = 8'h7F;
            @(posedge clk);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        total++;
        if (ir[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_ready_before: in_ready=%b required 1", ir[0]);
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({ov[0], ir[0]} !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset: out_valid,in_ready=%b required 00", {ov[0], ir[0]});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++;
        if (ir[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_release: in_ready=%b required 1", ir[0]);
        end
`ifdef MAC_BIAS_EN
        bias = 20'h80005;
        exp  = 20'h00004;
`else
        exp  = 20'h00009;
`endif
        push_n(9, 8'h01, 8'h01);
        run_group(0, 1'b0, 0, 1'b0, exp, "after_reset");
`ifdef MAC_BIAS_EN
        bias = 20'h00000;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mixed();
        test_saturate();
        test_zero();
        test_random_gaps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
